// File: rtl/axi_audio_lite_arbiter_if.sv
// AXI4-Lite master-side bundle between the audio arbiter and the AXI_AUDIO
// register slave. Each channel keeps its single-beat VALID/READY pair.
interface axi_audio_lite_arbiter_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_audio_lite_arbiter.sv
// Round-robin two-requester AXI4-Lite master for the AXI_AUDIO register slave.
// Port 0 carries sample traffic, port 1 configuration/status. One single-beat
// transaction is in flight at a time; completion returns on rsp_* to the owner.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; arbitrate and grant a requester
// WR_ADDR | AWVALID/WVALID driven, each dropped on its own handshake
// WR_RESP | BREADY high, waiting for the write response
// RD_ADDR | ARVALID driven until ARREADY
// RD_RESP | RREADY high, waiting for read data
module axi_audio_lite_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    axi_audio_lite_arbiter_if.master m_axi
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_RESP,
        RD_ADDR,
        RD_RESP
    } state_t;

    state_t                  state;
    logic                    last_grant;
    logic                    grant_q;
    logic                    sel;
    logic                    sel_write;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    aw_done;
    logic                    w_done;

    // On a tie the requester that did not win last time is chosen; otherwise the sole requester.
    assign sel       = (&req_valid) ? ~last_grant : req_valid[1];
    assign sel_write = sel ? req_write[1] : req_write[0];
    assign sel_addr  = sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
    assign sel_wdata = sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];

    // The accept pulse is decoded in the grant cycle itself so that the AXI
    // address phase can start on the very next clock; reset masks it.
    assign req_ready = (ARESETN && (state == IDLE) && (|req_valid)) ? (2'b01 << sel) : 2'b00;

    assign m_axi.awprot = 3'b000;
    assign m_axi.arprot = 3'b000;
    assign m_axi.wstrb  = {(DATA_WIDTH/8){1'b1}};

    // A write channel counts as complete once its VALID is down or handshakes this cycle.
    assign aw_done = !m_axi.awvalid || m_axi.awready;
    assign w_done  = !m_axi.wvalid  || m_axi.wready;

    // Transaction sequencer with all bus and response outputs registered.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            grant_q       <= 1'b0;
            rsp_valid     <= 2'b00;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            m_axi.awaddr  <= '0;
            m_axi.awvalid <= 1'b0;
            m_axi.wdata   <= '0;
            m_axi.wvalid  <= 1'b0;
            m_axi.bready  <= 1'b0;
            m_axi.araddr  <= '0;
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b0;
        end else begin
            rsp_valid <= 2'b00;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant_q    <= sel;
                        last_grant <= sel;
                        if (sel_write) begin
                            m_axi.awaddr  <= sel_addr;
                            m_axi.wdata   <= sel_wdata;
                            m_axi.awvalid <= 1'b1;
                            m_axi.wvalid  <= 1'b1;
                            state         <= WR_ADDR;
                        end else begin
                            m_axi.araddr  <= sel_addr;
                            m_axi.arvalid <= 1'b1;
                            state         <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR: begin
                    if (m_axi.awready) begin
                        m_axi.awvalid <= 1'b0;
                    end
                    if (m_axi.wready) begin
                        m_axi.wvalid <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        m_axi.bready <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi.bvalid) begin
                        m_axi.bready <= 1'b0;
                        rsp_valid    <= 2'b01 << grant_q;
                        rsp_resp     <= m_axi.bresp;
                        state        <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (m_axi.arready) begin
                        m_axi.arvalid <= 1'b0;
                        m_axi.rready  <= 1'b1;
                        state         <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (m_axi.rvalid) begin
                        m_axi.rready <= 1'b0;
                        rsp_rdata    <= m_axi.rdata;
                        rsp_resp     <= m_axi.rresp;
                        rsp_valid    <= 2'b01 << grant_q;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_audio_lite_arbiter.sv
// Directed bench for axi_audio_lite_arbiter with a small AXI_AUDIO slave model.
module tb_axi_audio_lite_arbiter;

    localparam int AW = 4;
    localparam int DW = 32;

    logic            ACLK = 1'b0;
    logic            ARESETN = 1'b0;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_ready;
    logic [1:0]      req_write = 2'b00;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*DW-1:0] req_wdata = '0;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;

    axi_audio_lite_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_axi ();

    axi_audio_lite_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .m_axi     (m_axi)
    );

    always #5 ACLK = ~ACLK;

    // slave knobs (written by the stimulus) and observable counters (written by the slave)
    int aw_delay = 0;
    bit b_hold   = 1'b0;
    bit force_en = 1'b0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0;

    int n_tests = 0;
    int n_fail  = 0;
    int wrong_port = 0;

    // Slave model: handshakes sampled on the rising edge, responses driven on the falling edge.
    logic [31:0] mem [4] = '{default: 32'h0};
    bit aw_seen = 0, w_seen = 0, ar_seen = 0, b_done = 0, r_done = 0;
    logic [3:0]  aw_addr_l = '0, ar_addr_l = '0;
    logic [31:0] w_data_l = '0;
    int aw_wait = 0;
    initial begin
        m_axi.awready = 0; m_axi.wready = 0; m_axi.bvalid = 0; m_axi.bresp = 0;
        m_axi.arready = 0; m_axi.rvalid = 0; m_axi.rresp = 0; m_axi.rdata = 0;
        forever begin
            @(posedge ACLK or negedge ACLK);
            if (ACLK) begin
                if (ARESETN) begin
                    if (m_axi.awvalid && m_axi.awready) begin aw_seen = 1; aw_addr_l = m_axi.awaddr; aw_hs++; end
                    if (m_axi.wvalid && m_axi.wready) begin w_seen = 1; w_data_l = m_axi.wdata; w_hs++; end
                    if (m_axi.bvalid && m_axi.bready) begin b_done = 1; b_hs++; end
                    if (m_axi.arvalid && m_axi.arready) begin ar_seen = 1; ar_addr_l = m_axi.araddr; ar_hs++; end
                    if (m_axi.rvalid && m_axi.rready) r_done = 1;
                end
            end else if (!ARESETN) begin
                m_axi.awready = 0; m_axi.wready = 0; m_axi.bvalid = 0; m_axi.arready = 0; m_axi.rvalid = 0;
                aw_seen = 0; w_seen = 0; ar_seen = 0; b_done = 0; r_done = 0; aw_wait = 0;
            end else begin
                if (m_axi.awvalid && !aw_seen) begin
                    m_axi.awready = (aw_wait >= aw_delay);
                    aw_wait++;
                end else begin
                    m_axi.awready = 0;
                    aw_wait = 0;
                end
                m_axi.wready = m_axi.wvalid && !w_seen;
                if (b_done) begin
                    m_axi.bvalid = 0; b_done = 0;
                end else if (aw_seen && w_seen && !b_hold && !m_axi.bvalid) begin
                    mem[aw_addr_l[3:2]] = w_data_l;
                    m_axi.bvalid = 1; m_axi.bresp = 2'b00;
                    aw_seen = 0; w_seen = 0;
                end
                m_axi.arready = m_axi.arvalid && !ar_seen;
                if (r_done) begin
                    m_axi.rvalid = 0; r_done = 0;
                end else if (ar_seen && !m_axi.rvalid) begin
                    m_axi.rvalid = 1;
                    m_axi.rdata  = force_en ? 32'hDEADBEEF : mem[ar_addr_l[3:2]];
                    m_axi.rresp  = force_en ? 2'b10 : 2'b00;
                    ar_seen = 0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One request from requester r; lat is the rsp cycle index counted from the grant cycle (-1 if none).
    task automatic xact(input int r, input logic wr, input logic [3:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic [1:0] rs, output int lat);
        bit got;
        lat = -1; rd = 'x; rs = 'x; got = 0;
        req_write[r] = wr; req_addr[r*AW +: AW] = a; req_wdata[r*DW +: DW] = d; req_valid[r] = 1'b1;
        #1;
        for (int k = 0; k < 50; k++) begin
            if (req_ready[r]) begin got = 1; break; end
            @(posedge ACLK); #1;
        end
        if (!got) begin req_valid[r] = 1'b0; return; end
        for (int k = 1; k < 50; k++) begin
            @(posedge ACLK); #1;
            if (k == 1) req_valid[r] = 1'b0;
            if (rsp_valid[1-r]) wrong_port++;
            if (rsp_valid[r]) begin lat = k; rd = rsp_rdata; rs = rsp_resp; break; end
        end
    endtask

    // Requester-0 write with a 6-cycle trace of AWVALID/WVALID/BREADY/rsp_valid[0] after the grant cycle.
    task automatic wr_trace(input string tag, input int dly, input logic [3:0] a, input logic [31:0] d,
                            input logic [5:0] e_aw, input logic [5:0] e_w, input logic [5:0] e_br, input logic [5:0] e_rsp);
        logic [5:0] s_aw, s_w, s_br, s_rsp;
        int aw0, w0, b0, unstable;
        bit got;
        s_aw = '0; s_w = '0; s_br = '0; s_rsp = '0;
        aw_delay = dly; aw0 = aw_hs; w0 = w_hs; b0 = b_hs; unstable = 0; got = 0;
        req_write[0] = 1'b1; req_addr[AW-1:0] = a; req_wdata[DW-1:0] = d; req_valid[0] = 1'b1;
        #1;
        for (int k = 0; k < 50; k++) begin
            if (req_ready[0]) begin got = 1; break; end
            @(posedge ACLK); #1;
        end
        check({tag, " grant"}, 32'(got), 32'd1);
        for (int c = 0; c < 6; c++) begin
            @(posedge ACLK); #1;
            if (c == 0) req_valid[0] = 1'b0;
            s_aw[c]  = m_axi.awvalid;
            s_w[c]   = m_axi.wvalid;
            s_br[c]  = m_axi.bready;
            s_rsp[c] = rsp_valid[0];
            if (m_axi.awvalid && m_axi.awaddr !== a) unstable++;
            if (m_axi.wvalid && m_axi.wdata !== d) unstable++;
        end
        check({tag, " awvalid trace"}, 32'(s_aw), 32'(e_aw));
        check({tag, " wvalid trace"}, 32'(s_w), 32'(e_w));
        check({tag, " bready trace"}, 32'(s_br), 32'(e_br));
        check({tag, " rsp_valid trace"}, 32'(s_rsp), 32'(e_rsp));
        check({tag, " addr/data stable"}, 32'(unstable), 32'd0);
        check({tag, " aw handshakes"}, 32'(aw_hs - aw0), 32'd1);
        check({tag, " w handshakes"}, 32'(w_hs - w0), 32'd1);
        check({tag, " b handshakes"}, 32'(b_hs - b0), 32'd1);
        aw_delay = 0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        int          lat, ng, nrsp, lastg, rsp_cnt;
        logic [5:0]  order;
        bit          got;

        // reset state
        repeat (3) @(posedge ACLK);
        #1;
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_rdata/resp", {rsp_rdata[29:0], rsp_resp}, 32'd0);
        check("rst valid/ready outs", 32'({m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready}), 32'd0);
        check("rst awaddr/araddr", 32'({m_axi.awaddr, m_axi.araddr}), 32'd0);
        check("rst wdata", m_axi.wdata, 32'd0);
        check("wstrb/prot", 32'({m_axi.wstrb, m_axi.awprot, m_axi.arprot}), 32'h3C0);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;

        // zero-wait writes then readback by requester 0
        for (int i = 0; i < 4; i++) begin
            xact(0, 1'b1, 4'(i*4), 32'(i+1), rd, rs, lat);
            check($sformatf("wr%0d latency", i), 32'(lat), 32'd3);
            check($sformatf("wr%0d resp", i), 32'(rs), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            xact(0, 1'b0, 4'(i*4), 32'h0, rd, rs, lat);
            check($sformatf("rd%0d latency", i), 32'(lat), 32'd3);
            check($sformatf("rd%0d data", i), rd, 32'(i+1));
            check($sformatf("rd%0d resp", i), 32'(rs), 32'd0);
        end
        check("wrong port rsp", 32'(wrong_port), 32'd0);

        // AW and W accepted in their first cycle, then AWREADY held off 3 cycles
        wr_trace("wr same-cycle", 0, 4'h8, 32'h33, 6'b000001, 6'b000001, 6'b000010, 6'b000100);
        check("rdata kept over write", rsp_rdata, 32'd4);
        wr_trace("wr aw delay3", 3, 4'hC, 32'h44, 6'b001111, 6'b000001, 6'b010000, 6'b100000);

        // error read on requester 1
        force_en = 1'b1;
        xact(1, 1'b0, 4'h4, 32'h0, rd, rs, lat);
        force_en = 1'b0;
        check("slverr latency", 32'(lat), 32'd3);
        check("slverr rdata", rd, 32'hDEADBEEF);
        check("slverr resp", 32'(rs), 32'd2);
        rsp_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge ACLK); #1;
            if (rsp_valid != 2'b00) rsp_cnt++;
        end
        check("slverr single pulse", 32'(rsp_cnt), 32'd0);

        // both requesters held valid: alternating grants starting with 0
        req_write = 2'b00; req_addr = {4'h4, 4'h0}; req_valid = 2'b11;
        #1;
        ng = 0; nrsp = 0; lastg = 0; order = '0;
        for (int k = 0; k < 200 && (ng < 6 || nrsp < 6); k++) begin
            if (rsp_valid != 2'b00) begin
                check($sformatf("fair rsp%0d port", nrsp), 32'(rsp_valid), 32'(2'b01 << lastg));
                nrsp++;
            end
            if (req_ready != 2'b00 && ng < 6) begin
                order[ng] = req_ready[1];
                lastg = int'(req_ready[1]);
                ng++;
            end
            @(posedge ACLK); #1;
            if (ng >= 6) req_valid = 2'b00;
            #1;
        end
        req_valid = 2'b00;
        check("fair grants", 32'(ng), 32'd6);
        check("fair responses", 32'(nrsp), 32'd6);
        check("fair order", 32'(order), 32'h2A);

        // reset while waiting for BVALID
        b_hold = 1'b1;
        req_write[0] = 1'b1; req_addr[AW-1:0] = 4'h4; req_wdata[DW-1:0] = 32'h77; req_valid[0] = 1'b1;
        #1;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            if (req_ready[0]) begin got = 1; break; end
            @(posedge ACLK); #1;
        end
        check("rstwr grant", 32'(got), 32'd1);
        @(posedge ACLK); #1;
        req_valid[0] = 1'b0;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            if (m_axi.bready) begin got = 1; break; end
            @(posedge ACLK); #1;
        end
        check("rstwr reached WR_RESP", 32'(got), 32'd1);
        #2;
        ARESETN = 1'b0;
        #1;
        check("async rst valid/ready outs", 32'({m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready}), 32'd0);
        check("async rst req/rsp", 32'({req_ready, rsp_valid, rsp_resp}), 32'd0);
        check("async rst rsp_rdata", rsp_rdata, 32'd0);
        check("async rst awaddr/wdata", m_axi.wdata | 32'(m_axi.awaddr), 32'd0);
        rsp_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge ACLK); #1;
            if (rsp_valid != 2'b00) rsp_cnt++;
        end
        b_hold = 1'b0;
        ARESETN = 1'b1;
        req_write = 2'b00; req_addr = {4'h8, 4'h4}; req_valid = 2'b11;
        #1;
        check("post-rst tie grant", 32'(req_ready), 32'd1);
        check("no rsp across reset", 32'(rsp_cnt), 32'd0);
        @(posedge ACLK); #1;
        req_valid = 2'b00;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            if (rsp_valid != 2'b00) begin got = 1; break; end
            @(posedge ACLK); #1;
        end
        check("post-rst rsp port", 32'(rsp_valid), 32'd1);
        check("post-rst rdata", rsp_rdata, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
